xorshift_checker: RTL and testbench

- Receive-side counterpart of the xorshift32 generator: consumes a stream of 32-bit words that the generator should have produced and checks each word against the predicted next value.
- Self-synchronises by seeding its predictor from the incoming data, locks after a run of correct predictions, then counts mismatches.
- Sits at the sink end of the PRNG test path as the built-in error checker for links and memories exercised by xorshift traffic.

---
 rtl/xorshift_checker.sv | 150 +++++++++++++++
 tb/tb_xorshift_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_checker.sv
// xorshift_checker: sink-side checker for an xorshift32 word stream.
// Seeds a predictor from the incoming words. After LOCK_N correct
// predictions it locks. While locked it runs as a flywheel and counts
// mismatching words. UNLOCK_N consecutive mismatches return it to search.
//
// Ports:
//   clk        rising-edge clock
//   arst       asynchronous reset, active-high
//   clear      synchronous clear (same effect as arst; beats in_valid)
//   in_valid   data_in carries a word this cycle
//   data_in    received 32-bit word
//   locked     registered, high while in LOCKED
//   err_pulse  registered, one-cycle pulse after a mismatching locked beat
//   err_count  registered, saturating mismatch count (LOCKED only)
module xorshift_checker #(
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [31:0]      data_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        exp_q;
  logic [RUN_W-1:0]   match_cnt_q;
  logic [RUN_W-1:0]   bad_run_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [CNT_W-1:0]   err_count_q;

  // xorshift32 next-value function
  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] x1;
    logic [31:0] x2;
    x1 = x ^ (x << 13);
    x2 = x1 ^ (x1 >> 17);
    return x2 ^ (x2 << 5);
  endfunction

  // Candidate next predictions: reseed from the data, or advance the flywheel
  logic [31:0]      exp_seed_d;
  logic [31:0]      exp_fly_d;
  logic [RUN_W-1:0] match_cnt_d;
  logic [RUN_W-1:0] bad_run_d;
  logic             hit_c;
  logic             zero_c;
  logic             cnt_max_c;

  assign exp_seed_d  = xs_next(data_in);
  assign exp_fly_d   = xs_next(exp_q);
  assign match_cnt_d = match_cnt_q + RUN_W'(1);
  assign bad_run_d   = bad_run_q + RUN_W'(1);
  assign hit_c       = (data_in == exp_q);
  assign zero_c      = (data_in == 32'd0);
  assign cnt_max_c   = &err_count_q;

  // Checker state machine with registered outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_SEARCH;
      exp_q       <= 32'd0;
      match_cnt_q <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else if (clear) begin
      state_q     <= S_SEARCH;
      exp_q       <= 32'd0;
      match_cnt_q <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          S_SEARCH: begin
            if (!zero_c) begin
              exp_q       <= exp_seed_d;
              match_cnt_q <= '0;
              state_q     <= S_VERIFY;
            end
          end
          S_VERIFY: begin
            if (hit_c) begin
              exp_q       <= exp_seed_d;
              match_cnt_q <= match_cnt_d;
              if (match_cnt_d == RUN_W'(LOCK_N)) begin
                state_q   <= S_LOCKED;
                locked_q  <= 1'b1;
                bad_run_q <= '0;
              end
            end else if (!zero_c) begin
              exp_q       <= exp_seed_d;
              match_cnt_q <= '0;
            end else begin
              state_q <= S_SEARCH;
            end
          end
          S_LOCKED: begin
            // Flywheel: never reseed from data so one bad word costs one error
            exp_q <= exp_fly_d;
            if (hit_c) begin
              bad_run_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (!cnt_max_c) begin
                err_count_q <= err_count_q + CNT_W'(1);
              end
              if (bad_run_d == RUN_W'(UNLOCK_N)) begin
                state_q     <= S_SEARCH;
                locked_q    <= 1'b0;
                match_cnt_q <= '0;
                bad_run_q   <= '0;
              end else begin
                bad_run_q <= bad_run_d;
              end
            end
          end
          default: begin
            state_q  <= S_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_xorshift_checker.sv
// tb_xorshift_checker: directed scoreboard bench for xorshift_checker.
// Instance m uses default parameters. Instance s uses LOCK_N=1 and CNT_W=2.
// Drivers push the expected {locked, err_pulse, err_count} for each beat.
// Monitors pop an entry on the falling edge after each sampled beat.
`timescale 1ns/1ps
module tb_xorshift_checker;

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] cnt;
  } resp_t;

  logic        clk = 1'b0;
  logic        arst;
  logic        m_clear, m_vld;
  logic [31:0] m_data;
  logic        m_locked, m_ep;
  logic [15:0] m_cnt;
  logic        s_clear, s_vld;
  logic [31:0] s_data;
  logic        s_locked, s_ep;
  logic [1:0]  s_cnt;

  resp_t q_m[$];
  resp_t q_s[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  xorshift_checker #(.LOCK_N(4), .UNLOCK_N(3), .CNT_W(16)) dut_m (
    .clk(clk), .arst(arst), .clear(m_clear), .in_valid(m_vld), .data_in(m_data),
    .locked(m_locked), .err_pulse(m_ep), .err_count(m_cnt)
  );

  xorshift_checker #(.LOCK_N(1), .UNLOCK_N(3), .CNT_W(2)) dut_s (
    .clk(clk), .arst(arst), .clear(s_clear), .in_valid(s_vld), .data_in(s_data),
    .locked(s_locked), .err_pulse(s_ep), .err_count(s_cnt)
  );

  function automatic logic [31:0] f(input logic [31:0] x);
    logic [31:0] a;
    logic [31:0] b;
    a = x ^ (x << 13);
    b = a ^ (a >> 17);
    return b ^ (b << 5);
  endfunction

  // Monitors: note which edges sampled a beat or a clear
  logic m_seen, s_seen;
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_seen <= 1'b0;
      s_seen <= 1'b0;
    end else begin
      m_seen <= m_vld | m_clear;
      s_seen <= s_vld | s_clear;
    end
  end

  always @(negedge clk) begin : mon_m
    resp_t e;
    total++;
    if (m_seen) begin
      if (q_m.size() == 0) begin
        bad++;
        $display("FAIL m_unexpected_beat t=%0t", $time);
      end else begin
        e = q_m.pop_front();
        if ({m_locked, m_ep, m_cnt} !== e) begin
          bad++;
          $display("FAIL m_beat t=%0t got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                   $time, m_locked, m_ep, m_cnt, e.lk, e.ep, e.cnt);
        end
      end
    end else if (m_ep !== 1'b0) begin
      bad++;
      $display("FAIL m_idle_pulse t=%0t got ep=%0b want 0", $time, m_ep);
    end
  end

  always @(negedge clk) begin : mon_s
    resp_t e;
    total++;
    if (s_seen) begin
      if (q_s.size() == 0) begin
        bad++;
        $display("FAIL s_unexpected_beat t=%0t", $time);
      end else begin
        e = q_s.pop_front();
        if ({s_locked, s_ep, 16'(s_cnt)} !== e) begin
          bad++;
          $display("FAIL s_beat t=%0t got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                   $time, s_locked, s_ep, s_cnt, e.lk, e.ep, e.cnt);
        end
      end
    end else if (s_ep !== 1'b0) begin
      bad++;
      $display("FAIL s_idle_pulse t=%0t got ep=%0b want 0", $time, s_ep);
    end
  end

  // Drivers: inputs change 1ns after the rising edge
  task automatic m_beat(input logic [31:0] d, input logic lk, input logic ep, input int cnt);
    @(posedge clk); #1;
    m_vld = 1'b1; m_data = d;
    q_m.push_back(resp_t'({lk, ep, 16'(cnt)}));
  endtask

  task automatic m_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      m_vld = 1'b0; m_clear = 1'b0;
    end
  endtask

  // Clear asserted together with a valid beat: clear must win
  task automatic m_clr(input logic [31:0] d);
    @(posedge clk); #1;
    m_clear = 1'b1; m_vld = 1'b1; m_data = d;
    q_m.push_back(resp_t'({1'b0, 1'b0, 16'd0}));
    m_idle(1);
  endtask

  task automatic s_beat(input logic [31:0] d, input logic lk, input logic ep, input int cnt);
    @(posedge clk); #1;
    s_vld = 1'b1; s_data = d;
    q_s.push_back(resp_t'({lk, ep, 16'(cnt)}));
  endtask

  task automatic s_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_vld = 1'b0; s_clear = 1'b0;
    end
  endtask

  task automatic s_clr(input logic [31:0] d);
    @(posedge clk); #1;
    s_clear = 1'b1; s_vld = 1'b1; s_data = d;
    q_s.push_back(resp_t'({1'b0, 1'b0, 16'd0}));
    s_idle(1);
  endtask

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] w;
    logic [31:0] d;
    logic [31:0] bad_w [3];
    bad_w[0] = 32'hDEADBEEF;
    bad_w[1] = 32'h12345678;
    bad_w[2] = 32'hCAFEF00D;

    arst = 1'b1;
    m_clear = 1'b0; m_vld = 1'b0; m_data = '0;
    s_clear = 1'b0; s_vld = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m", {m_locked, m_ep, m_cnt}, 18'd0);
    check("reset_s", {s_locked, s_ep, 16'(s_cnt)}, 18'd0);
    @(negedge clk); arst = 1'b0;

    // LOCK_N=1: seed 1 then f(1) locks
    s_beat(32'h00000001, 1'b0, 1'b0, 0);
    s_beat(32'h00042021, 1'b1, 1'b0, 0);
    // CNT_W=2 saturation: 5 errors separated by good words
    v = f(32'h00042021);
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) s_beat(v ^ 32'h80000000, 1'b1, 1'b1, (k / 2 + 1 > 3) ? 3 : k / 2 + 1);
      else            s_beat(v, 1'b1, 1'b0, (k / 2 + 1 > 3) ? 3 : k / 2 + 1);
      v = f(v);
    end
    s_clr(v);
    s_idle(2);

    // Clean 40-beat stream with gaps
    v = 32'h92D68CA2;
    for (int i = 1; i <= 40; i++) begin
      m_beat(v, i >= 5, 1'b0, 0);
      v = f(v);
      if (i % 7 == 0) m_idle(1);
    end
    m_idle(2);

    // Single corrupted word at beat 20, then clear mid-stream and relock
    m_clr(32'h0);
    v = 32'h92D68CA2;
    for (int i = 1; i <= 40; i++) begin
      d = (i == 20) ? (v ^ 32'h00000001) : v;
      m_beat(d, i >= 5, i == 20, (i >= 20) ? 1 : 0);
      v = f(v);
    end
    m_clr(v);
    for (int i = 1; i <= 6; i++) begin
      m_beat(v, i >= 5, 1'b0, 0);
      v = f(v);
    end
    m_idle(2);

    // Three consecutive bad words unlock, then relock with count held
    m_clr(32'h0);
    v = 32'h92D68CA2;
    for (int i = 1; i <= 8; i++) begin
      m_beat(v, i >= 5, 1'b0, 0);
      v = f(v);
    end
    for (int k = 0; k < 3; k++) begin
      m_beat(bad_w[k], k < 2, 1'b1, k + 1);
      v = f(v);
    end
    for (int i = 1; i <= 6; i++) begin
      m_beat(v, i >= 5, 1'b0, 3);
      v = f(v);
    end
    m_idle(2);

    // Asynchronous reset between edges clears outputs immediately
    @(negedge clk); #2;
    arst = 1'b1;
    #1;
    check("arst_immediate", {m_locked, m_ep, m_cnt}, 18'd0);
    @(negedge clk); #1;
    arst = 1'b0;

    // Zeros in SEARCH, wrong word in VERIFY reseeds
    m_beat(32'h0, 1'b0, 1'b0, 0);
    m_beat(32'h0, 1'b0, 1'b0, 0);
    v = 32'h92D68CA2;
    m_beat(v, 1'b0, 1'b0, 0);
    m_beat(f(v), 1'b0, 1'b0, 0);
    m_beat(32'h11111111, 1'b0, 1'b0, 0);
    w = f(32'h11111111);
    for (int i = 1; i <= 4; i++) begin
      m_beat(w, i == 4, 1'b0, 0);
      w = f(w);
    end
    m_idle(3);

    check("queue_m_empty", 18'(q_m.size()), 18'd0);
    check("queue_s_empty", 18'(q_s.size()), 18'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
